// File: rtl/uart_pkg.sv
// Shared definitions for the UART Avalon-MM CSR block: register map, IRQ bit
// positions, bus FSM states and the character-width clamp helper.
package uart_pkg;

    localparam logic [2:0] ADDR_CONTROL  = 3'd0;
    localparam logic [2:0] ADDR_BAUD     = 3'd1;
    localparam logic [2:0] ADDR_TX_FILL  = 3'd2;
    localparam logic [2:0] ADDR_RX_FILL  = 3'd3;
    localparam logic [2:0] ADDR_TX_DATA  = 3'd4;
    localparam logic [2:0] ADDR_RX_DATA  = 3'd5;
    localparam logic [2:0] ADDR_IRQ_EN   = 3'd6;
    localparam logic [2:0] ADDR_IRQ_STAT = 3'd7;

    localparam int IRQ_RX_NOT_EMPTY = 0;
    localparam int IRQ_TX_EMPTY     = 1;
    localparam int IRQ_RX_OVERRUN   = 2;
    localparam int IRQ_TX_OVERFLOW  = 3;
    localparam int IRQ_W            = 4;

    localparam logic [3:0] DBITS_MIN = 4'd5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd1,
        RX_WAIT = 2'd2
    } bus_state_t;

    // Character widths outside the legal window fall back to the widest one.
    function automatic logic [3:0] clamp_dbits(input logic [3:0] req,
                                               input logic [3:0] max_bits);
        return ((req < DBITS_MIN) || (req > max_bits)) ? max_bits : req;
    endfunction

endpackage

// File: rtl/uart_irq_ctrl.sv
// Interrupt status/enable registers and the registered level interrupt output.
// Bits 0/1 mirror live FIFO flags; bits 2/3 are sticky and write-one-to-clear.
module uart_irq_ctrl
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fifo_rx_empty_i,
    input  logic              fifo_tx_empty_i,
    input  logic              rx_overrun_i,
    input  logic              tx_overflow_i,
    input  logic              en_we_i,
    input  logic [IRQ_W-1:0]  en_wdata_i,
    input  logic              clr_overrun_i,
    input  logic              clr_overflow_i,
    output logic [IRQ_W-1:0]  irq_en_o,
    output logic [IRQ_W-1:0]  irq_stat_o,
    output logic              irq_o
);

    logic [IRQ_W-1:0] en_q, en_d;
    logic             overrun_q, overrun_d;
    logic             overflow_q, overflow_d;
    logic             irq_q, irq_d;
    logic [IRQ_W-1:0] stat_cur, stat_d;

    always_comb begin
        en_d       = en_we_i ? en_wdata_i : en_q;
        // A set arriving in the same cycle as a clear must survive.
        overrun_d  = rx_overrun_i  | (overrun_q  & ~clr_overrun_i);
        overflow_d = tx_overflow_i | (overflow_q & ~clr_overflow_i);

        stat_cur                   = '0;
        stat_cur[IRQ_RX_NOT_EMPTY] = ~fifo_rx_empty_i;
        stat_cur[IRQ_TX_EMPTY]     = fifo_tx_empty_i;
        stat_cur[IRQ_RX_OVERRUN]   = overrun_q;
        stat_cur[IRQ_TX_OVERFLOW]  = overflow_q;

        stat_d                     = stat_cur;
        stat_d[IRQ_RX_OVERRUN]     = overrun_d;
        stat_d[IRQ_TX_OVERFLOW]    = overflow_d;

        // Built from next-state values so irq_o rises one clock after the cause.
        irq_d = |(stat_d & en_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q       <= '0;
            overrun_q  <= 1'b0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            en_q       <= en_d;
            overrun_q  <= overrun_d;
            overflow_q <= overflow_d;
            irq_q      <= irq_d;
        end
    end

    assign irq_en_o   = en_q;
    assign irq_stat_o = stat_cur;
    assign irq_o      = irq_q;

endmodule

// File: rtl/uart_avmm_csr.sv
// Avalon-MM CSR front end for a UART: configuration registers, TX push, RX pop
// with variable-latency read data, and the interrupt controller.
module uart_avmm_csr
    import uart_pkg::*;
#(
    parameter int          DATA_BITS      = 8,
    parameter int          FILL_W         = 16,
    parameter logic [11:0] BAUD_FREQ_RST  = 12'h001,
    parameter logic [15:0] BAUD_LIMIT_RST = 16'h0001
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic                 avmms_write_i,
    input  logic                 avmms_read_i,
    input  logic [2:0]           avmms_address_i,
    input  logic [31:0]          avmms_writedata_i,
    input  logic [3:0]           avmms_byteenable_i,
    output logic                 avmms_waitrequest_o,
    output logic [31:0]          avmms_readdata_o,

    output logic                 cr_pbit,
    output logic                 cr_ptype,
    output logic [1:0]           cr_sbit,
    output logic [3:0]           cr_dbits,
    output logic [11:0]          cr_baud_freq,
    output logic [15:0]          cr_baud_limit,

    input  logic                 fifo_tx_empty,
    input  logic                 fifo_tx_full,
    input  logic [FILL_W-1:0]    fifo_tx_fill,
    output logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_valid,

    input  logic                 fifo_rx_empty,
    input  logic                 fifo_rx_full,
    input  logic [FILL_W-1:0]    fifo_rx_fill,
    input  logic                 rx_overrun_i,
    output logic                 rx_read,
    input  logic [DATA_BITS:0]   rx_readdata,
    input  logic                 rx_readdatavalid,

    output logic                 irq_o,
    output logic [1:0]           fsm_state_o
);

    localparam logic [3:0] DBITS_MAX = 4'(DATA_BITS);

    bus_state_t           state_q;
    logic                 wait_q;
    logic [31:0]          rdata_q;
    logic                 tx_valid_q;
    logic [DATA_BITS-1:0] tx_data_q;
    logic                 rx_read_q;

    logic                 pbit_q, ptype_q;
    logic [1:0]           sbit_q;
    logic [3:0]           dbits_q;
    logic [11:0]          freq_q;
    logic [15:0]          limit_q;

    logic                 wr_en, rd_en;
    logic                 tx_push, tx_drop;
    logic                 irq_en_we, irq_w1c_we;
    logic [31:0]          rd_mux;
    logic [31:0]          rx_word;
    logic [IRQ_W-1:0]     irq_en, irq_stat;
    logic                 unused_wdata;

    assign unused_wdata = ^avmms_writedata_i[31:28];

    // Requests are only sampled in IDLE; a write wins if both strobes are high.
    always_comb begin
        wr_en      = (state_q == IDLE) && avmms_write_i;
        rd_en      = (state_q == IDLE) && !avmms_write_i && avmms_read_i;
        tx_push    = wr_en && (avmms_address_i == ADDR_TX_DATA) && !fifo_tx_full;
        tx_drop    = wr_en && (avmms_address_i == ADDR_TX_DATA) && fifo_tx_full;
        irq_en_we  = wr_en && (avmms_address_i == ADDR_IRQ_EN) && avmms_byteenable_i[0];
        irq_w1c_we = wr_en && (avmms_address_i == ADDR_IRQ_STAT) && avmms_byteenable_i[0];
        rx_word    = {1'b1, {(30-DATA_BITS){1'b0}}, rx_readdata};

        rd_mux = '0;
        case (avmms_address_i)
            ADDR_CONTROL:  rd_mux = {16'h0, dbits_q, sbit_q, ptype_q, pbit_q, 4'h0,
                                     fifo_tx_full, fifo_tx_empty, fifo_rx_full, fifo_rx_empty};
            ADDR_BAUD:     rd_mux = {4'h0, freq_q, limit_q};
            ADDR_TX_FILL:  rd_mux = 32'(fifo_tx_fill);
            ADDR_RX_FILL:  rd_mux = 32'(fifo_rx_fill);
            ADDR_IRQ_EN:   rd_mux = {{(32-IRQ_W){1'b0}}, irq_en};
            ADDR_IRQ_STAT: rd_mux = {{(32-IRQ_W){1'b0}}, irq_stat};
            default:       rd_mux = '0;
        endcase
    end

    // Bus FSM; waitrequest drops only for the single ACK cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wait_q     <= 1'b1;
            rdata_q    <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            rx_read_q  <= 1'b0;
        end else begin
            wait_q     <= 1'b1;
            tx_valid_q <= 1'b0;
            rx_read_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wr_en) begin
                        state_q <= ACK;
                        wait_q  <= 1'b0;
                        rdata_q <= '0;
                        if (tx_push) begin
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= avmms_writedata_i[DATA_BITS-1:0];
                        end
                    end else if (rd_en) begin
                        if ((avmms_address_i == ADDR_RX_DATA) && !fifo_rx_empty) begin
                            state_q   <= RX_WAIT;
                            rx_read_q <= 1'b1;
                        end else begin
                            state_q <= ACK;
                            wait_q  <= 1'b0;
                            rdata_q <= rd_mux;
                        end
                    end
                end
                RX_WAIT: begin
                    if (rx_readdatavalid) begin
                        state_q <= ACK;
                        wait_q  <= 1'b0;
                        rdata_q <= rx_word;
                    end
                end
                ACK:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Configuration registers, written lane by lane.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pbit_q  <= 1'b0;
            ptype_q <= 1'b0;
            sbit_q  <= 2'b00;
            dbits_q <= DBITS_MAX;
            freq_q  <= BAUD_FREQ_RST;
            limit_q <= BAUD_LIMIT_RST;
        end else if (wr_en) begin
            if ((avmms_address_i == ADDR_CONTROL) && avmms_byteenable_i[1]) begin
                pbit_q  <= avmms_writedata_i[8];
                ptype_q <= avmms_writedata_i[9];
                sbit_q  <= avmms_writedata_i[11:10];
                dbits_q <= clamp_dbits(avmms_writedata_i[15:12], DBITS_MAX);
            end
            if (avmms_address_i == ADDR_BAUD) begin
                if (avmms_byteenable_i[0]) limit_q[7:0]  <= avmms_writedata_i[7:0];
                if (avmms_byteenable_i[1]) limit_q[15:8] <= avmms_writedata_i[15:8];
                if (avmms_byteenable_i[2]) freq_q[7:0]   <= avmms_writedata_i[23:16];
                if (avmms_byteenable_i[3]) freq_q[11:8]  <= avmms_writedata_i[27:24];
            end
        end
    end

    uart_irq_ctrl u_irq (
        .clk             (clk),
        .reset_n         (reset_n),
        .fifo_rx_empty_i (fifo_rx_empty),
        .fifo_tx_empty_i (fifo_tx_empty),
        .rx_overrun_i    (rx_overrun_i),
        .tx_overflow_i   (tx_drop),
        .en_we_i         (irq_en_we),
        .en_wdata_i      (avmms_writedata_i[IRQ_W-1:0]),
        .clr_overrun_i   (irq_w1c_we && avmms_writedata_i[IRQ_RX_OVERRUN]),
        .clr_overflow_i  (irq_w1c_we && avmms_writedata_i[IRQ_TX_OVERFLOW]),
        .irq_en_o        (irq_en),
        .irq_stat_o      (irq_stat),
        .irq_o           (irq_o)
    );

    assign avmms_waitrequest_o = wait_q;
    assign avmms_readdata_o    = rdata_q;
    assign tx_valid            = tx_valid_q;
    assign tx_data             = tx_data_q;
    assign rx_read             = rx_read_q;
    assign cr_pbit             = pbit_q;
    assign cr_ptype            = ptype_q;
    assign cr_sbit             = sbit_q;
    assign cr_dbits            = dbits_q;
    assign cr_baud_freq        = freq_q;
    assign cr_baud_limit       = limit_q;
    assign fsm_state_o         = state_q;

endmodule

// File: tb/tb_uart_avmm_csr.sv
// Directed bench for uart_avmm_csr: a register-access vector table plus
// hand-written sequences for TX push/drop, RX pop latency, IRQ and reset abort.
module tb_uart_avmm_csr;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        avmms_write_i, avmms_read_i;
    logic [2:0]  avmms_address_i;
    logic [31:0] avmms_writedata_i;
    logic [3:0]  avmms_byteenable_i;
    logic        avmms_waitrequest_o;
    logic [31:0] avmms_readdata_o;
    logic        cr_pbit, cr_ptype;
    logic [1:0]  cr_sbit;
    logic [3:0]  cr_dbits;
    logic [11:0] cr_baud_freq;
    logic [15:0] cr_baud_limit;
    logic        fifo_tx_empty, fifo_tx_full;
    logic [15:0] fifo_tx_fill;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        fifo_rx_empty, fifo_rx_full;
    logic [15:0] fifo_rx_fill;
    logic        rx_overrun_i;
    logic        rx_read;
    logic [8:0]  rx_readdata;
    logic        rx_readdatavalid;
    logic        irq_o;
    logic [1:0]  fsm_state_o;

    uart_avmm_csr #(
        .DATA_BITS(8), .FILL_W(16), .BAUD_FREQ_RST(12'h001), .BAUD_LIMIT_RST(16'h0001)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .avmms_write_i(avmms_write_i), .avmms_read_i(avmms_read_i),
        .avmms_address_i(avmms_address_i), .avmms_writedata_i(avmms_writedata_i),
        .avmms_byteenable_i(avmms_byteenable_i), .avmms_waitrequest_o(avmms_waitrequest_o),
        .avmms_readdata_o(avmms_readdata_o),
        .cr_pbit(cr_pbit), .cr_ptype(cr_ptype), .cr_sbit(cr_sbit), .cr_dbits(cr_dbits),
        .cr_baud_freq(cr_baud_freq), .cr_baud_limit(cr_baud_limit),
        .fifo_tx_empty(fifo_tx_empty), .fifo_tx_full(fifo_tx_full), .fifo_tx_fill(fifo_tx_fill),
        .tx_data(tx_data), .tx_valid(tx_valid),
        .fifo_rx_empty(fifo_rx_empty), .fifo_rx_full(fifo_rx_full), .fifo_rx_fill(fifo_rx_fill),
        .rx_overrun_i(rx_overrun_i), .rx_read(rx_read), .rx_readdata(rx_readdata),
        .rx_readdatavalid(rx_readdatavalid),
        .irq_o(irq_o), .fsm_state_o(fsm_state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    // Pulse counters sampled on the falling edge.
    int         tx_cnt = 0;
    int         rx_cnt = 0;
    logic [7:0] tx_last = '0;
    always @(negedge clk) begin
        if (tx_valid) begin
            tx_cnt  <= tx_cnt + 1;
            tx_last <= tx_data;
        end
        if (rx_read) rx_cnt <= rx_cnt + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_op(input logic wr, input logic [2:0] a, input logic [31:0] d,
                          input logic [3:0] be, output logic [31:0] rd, output int wc,
                          output logic ok, output logic one);
        @(negedge clk);
        avmms_write_i      = wr;
        avmms_read_i       = ~wr;
        avmms_address_i    = a;
        avmms_writedata_i  = d;
        avmms_byteenable_i = be;
        wc = 0;
        ok = 1'b0;
        rd = '0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (!avmms_waitrequest_o) begin
                ok = 1'b1;
                rd = avmms_readdata_o;
            end else begin
                wc++;
            end
        end
        avmms_write_i = 1'b0;
        avmms_read_i  = 1'b0;
        @(negedge clk);
        one = avmms_waitrequest_o;
    endtask

    task automatic rx_respond(input logic [8:0] d, input int delay, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rx_read) seen = 1'b1;
        end
        if (seen) begin
            repeat (delay) @(negedge clk);
            rx_readdata      = d;
            rx_readdatavalid = 1'b1;
            @(negedge clk);
            rx_readdatavalid = 1'b0;
        end
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [2:0] addr, input logic [31:0] data,
                                input logic [3:0] be, input logic [31:0] exp);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.be = be; v.exp = exp;
        return v;
    endfunction

    initial begin
        vec_t        vecs[$];
        logic [31:0] rd;
        int          wc, c0;
        logic        ok, one, seen;

        reset_n = 1'b0;
        avmms_write_i = 0; avmms_read_i = 0; avmms_address_i = 0;
        avmms_writedata_i = 0; avmms_byteenable_i = 0;
        fifo_tx_empty = 1; fifo_tx_full = 0; fifo_tx_fill = 16'h0012;
        fifo_rx_empty = 1; fifo_rx_full = 0; fifo_rx_fill = 16'h0034;
        rx_overrun_i = 0; rx_readdata = 0; rx_readdatavalid = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        check("rst_waitreq", 32'(avmms_waitrequest_o), 32'd1);
        check("rst_readdata", avmms_readdata_o, 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_rx_read", 32'(rx_read), 32'd0);
        check("rst_irq", 32'(irq_o), 32'd0);
        check("rst_fsm", 32'(fsm_state_o), 32'd0);
        check("rst_cfg", {16'h0, cr_dbits, cr_sbit, cr_ptype, cr_pbit, 8'h0}, 32'h0000_8000);
        check("rst_baud", {4'h0, cr_baud_freq, cr_baud_limit}, 32'h0001_0001);

        // CONTROL write through byte lane 1 only
        bus_op(1'b1, 3'd0, 32'h0000_0B00, 4'b0010, rd, wc, ok, one);
        check("ctl_ack", 32'(ok), 32'd1);
        check("ctl_wait_cycles", 32'(wc), 32'd0);
        check("ctl_ack_one_cycle", 32'(one), 32'd1);
        check("ctl_pbit", 32'(cr_pbit), 32'd1);
        check("ctl_ptype", 32'(cr_ptype), 32'd1);
        check("ctl_sbit", 32'(cr_sbit), 32'd2);
        check("ctl_dbits_clamp0", 32'(cr_dbits), 32'd8);

        vecs.push_back(mk(0, 3'd0, 32'h0, 4'hF, 32'h0000_8B05));
        vecs.push_back(mk(1, 3'd0, 32'hFFFF_6000, 4'b0010, 32'h0));
        vecs.push_back(mk(0, 3'd0, 32'h0, 4'hF, 32'h0000_6005));
        vecs.push_back(mk(1, 3'd0, 32'h0000_F000, 4'b0010, 32'h0));
        vecs.push_back(mk(0, 3'd0, 32'h0, 4'hF, 32'h0000_8005));
        vecs.push_back(mk(1, 3'd0, 32'h0000_4FFF, 4'b0001, 32'h0));
        vecs.push_back(mk(0, 3'd0, 32'h0, 4'hF, 32'h0000_8005));
        vecs.push_back(mk(1, 3'd0, 32'h0000_5000, 4'b0010, 32'h0));
        vecs.push_back(mk(0, 3'd0, 32'h0, 4'hF, 32'h0000_5005));
        vecs.push_back(mk(1, 3'd0, 32'h0000_4000, 4'b0010, 32'h0));
        vecs.push_back(mk(0, 3'd0, 32'h0, 4'hF, 32'h0000_8005));
        vecs.push_back(mk(0, 3'd1, 32'h0, 4'hF, 32'h0001_0001));
        vecs.push_back(mk(1, 3'd1, 32'h0064_0208, 4'b0011, 32'h0));
        vecs.push_back(mk(0, 3'd1, 32'h0, 4'hF, 32'h0001_0208));
        vecs.push_back(mk(1, 3'd1, 32'hFFAB_CDEF, 4'b1100, 32'h0));
        vecs.push_back(mk(0, 3'd1, 32'h0, 4'hF, 32'h0FAB_0208));
        vecs.push_back(mk(0, 3'd2, 32'h0, 4'hF, 32'h0000_0012));
        vecs.push_back(mk(0, 3'd3, 32'h0, 4'hF, 32'h0000_0034));
        vecs.push_back(mk(1, 3'd2, 32'hFFFF_FFFF, 4'hF, 32'h0));
        vecs.push_back(mk(0, 3'd2, 32'h0, 4'hF, 32'h0000_0012));
        vecs.push_back(mk(1, 3'd6, 32'h0000_0005, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 3'd6, 32'h0, 4'hF, 32'h0000_0000));
        vecs.push_back(mk(1, 3'd6, 32'h0000_000A, 4'b0001, 32'h0));
        vecs.push_back(mk(0, 3'd6, 32'h0, 4'hF, 32'h0000_000A));
        vecs.push_back(mk(1, 3'd6, 32'h0000_0000, 4'b0001, 32'h0));
        vecs.push_back(mk(0, 3'd6, 32'h0, 4'hF, 32'h0000_0000));
        vecs.push_back(mk(0, 3'd7, 32'h0, 4'hF, 32'h0000_0002));
        vecs.push_back(mk(0, 3'd4, 32'h0, 4'hF, 32'h0000_0000));

        foreach (vecs[i]) begin
            bus_op(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be, rd, wc, ok, one);
            check($sformatf("vec%0d_ack", i), 32'(ok), 32'd1);
            check($sformatf("vec%0d_wait_cycles", i), 32'(wc), 32'd0);
            check($sformatf("vec%0d_ack_one_cycle", i), 32'(one), 32'd1);
            if (!vecs[i].wr) check($sformatf("vec%0d_rdata_a%0d", i, vecs[i].addr), rd, vecs[i].exp);
        end
        check("baud_freq_port", 32'(cr_baud_freq), 32'h0000_0FAB);
        check("baud_limit_port", 32'(cr_baud_limit), 32'h0000_0208);

        // TX push, then drop on full FIFO
        c0 = tx_cnt;
        bus_op(1'b1, 3'd4, 32'h0000_01A5, 4'hF, rd, wc, ok, one);
        check("tx_pulses", 32'(tx_cnt - c0), 32'd1);
        check("tx_data", 32'(tx_last), 32'h0000_00A5);
        fifo_tx_full = 1'b1;
        fifo_tx_empty = 1'b0;
        c0 = tx_cnt;
        bus_op(1'b1, 3'd4, 32'h0000_01A5, 4'hF, rd, wc, ok, one);
        check("tx_full_ack", 32'(ok), 32'd1);
        check("tx_full_no_pulse", 32'(tx_cnt - c0), 32'd0);
        bus_op(1'b0, 3'd7, 32'h0, 4'hF, rd, wc, ok, one);
        check("irq_stat_overflow", rd, 32'h0000_0008);
        bus_op(1'b1, 3'd7, 32'h0000_0008, 4'b0001, rd, wc, ok, one);
        bus_op(1'b0, 3'd7, 32'h0, 4'hF, rd, wc, ok, one);
        check("irq_stat_w1c", rd, 32'h0000_0000);
        fifo_tx_full = 1'b0;
        fifo_tx_empty = 1'b1;

        // RX pop with three-cycle read latency
        fifo_rx_empty = 1'b0;
        c0 = rx_cnt;
        fork
            bus_op(1'b0, 3'd5, 32'h0, 4'hF, rd, wc, ok, one);
            rx_respond(9'h13C, 3, seen);
        join
        check("rx_ack", 32'(ok), 32'd1);
        check("rx_read_seen", 32'(seen), 32'd1);
        check("rx_read_pulses", 32'(rx_cnt - c0), 32'd1);
        check("rx_rdata", rd, 32'h8000_013C);
        check("rx_ack_one_cycle", 32'(one), 32'd1);
        fifo_rx_empty = 1'b1;
        c0 = rx_cnt;
        bus_op(1'b0, 3'd5, 32'h0, 4'hF, rd, wc, ok, one);
        check("rx_empty_ack_wait", 32'(wc), 32'd0);
        check("rx_empty_rdata", rd, 32'h0000_0000);
        check("rx_empty_no_read", 32'(rx_cnt - c0), 32'd0);

        // Overrun interrupt and set-beats-clear
        bus_op(1'b1, 3'd6, 32'h0000_0004, 4'b0001, rd, wc, ok, one);
        check("irq_idle", 32'(irq_o), 32'd0);
        @(negedge clk);
        rx_overrun_i = 1'b1;
        @(negedge clk);
        rx_overrun_i = 1'b0;
        check("irq_after_overrun", 32'(irq_o), 32'd1);
        @(negedge clk);
        avmms_write_i = 1'b1; avmms_address_i = 3'd7;
        avmms_writedata_i = 32'h4; avmms_byteenable_i = 4'b0001;
        rx_overrun_i = 1'b1;
        @(negedge clk);
        rx_overrun_i = 1'b0;
        check("w1c_race_ack", 32'(avmms_waitrequest_o), 32'd0);
        avmms_write_i = 1'b0;
        @(negedge clk);
        bus_op(1'b0, 3'd7, 32'h0, 4'hF, rd, wc, ok, one);
        check("w1c_race_stat", rd, 32'h0000_0006);
        check("w1c_race_irq", 32'(irq_o), 32'd1);
        bus_op(1'b1, 3'd7, 32'h0000_0004, 4'b0001, rd, wc, ok, one);
        check("w1c_irq_low", 32'(irq_o), 32'd0);
        bus_op(1'b0, 3'd7, 32'h0, 4'hF, rd, wc, ok, one);
        check("w1c_stat", rd, 32'h0000_0002);

        // Reset asserted mid RX_WAIT
        bus_op(1'b1, 3'd0, 32'h0000_0B00, 4'b0010, rd, wc, ok, one);
        bus_op(1'b1, 3'd6, 32'h0000_0001, 4'b0001, rd, wc, ok, one);
        fifo_rx_empty = 1'b0;
        @(negedge clk);
        check("pre_rst_irq", 32'(irq_o), 32'd1);
        avmms_read_i = 1'b1; avmms_address_i = 3'd5;
        @(negedge clk);
        check("pre_rst_fsm_rx_wait", 32'(fsm_state_o), 32'd2);
        check("pre_rst_rx_read", 32'(rx_read), 32'd1);
        reset_n = 1'b0;
        avmms_read_i = 1'b0;
        #1;
        check("async_rst_fsm", 32'(fsm_state_o), 32'd0);
        check("async_rst_rx_read", 32'(rx_read), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        c0 = rx_cnt;
        rx_readdata = 9'h1FF;
        rx_readdatavalid = 1'b1;
        @(negedge clk);
        rx_readdatavalid = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_fsm_idle", 32'(fsm_state_o), 32'd0);
        check("abort_waitreq", 32'(avmms_waitrequest_o), 32'd1);
        check("abort_readdata", avmms_readdata_o, 32'd0);
        check("abort_tx_valid", 32'(tx_valid), 32'd0);
        check("abort_rx_read", 32'(rx_cnt - c0), 32'd0);
        check("abort_irq", 32'(irq_o), 32'd0);
        check("abort_cfg", {16'h0, cr_dbits, cr_sbit, cr_ptype, cr_pbit, 8'h0}, 32'h0000_8000);
        check("abort_baud", {4'h0, cr_baud_freq, cr_baud_limit}, 32'h0001_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_avmm_csr.md
UART_AVMM_CSR -- requirements
Module: uart_avmm_csr

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning maximum UART character width, legal range 5..9.
REQ-002 SHALL have parameter FILL_W, default 16, meaning the width of the FIFO fill-level inputs.
REQ-003 SHALL have parameter BAUD_FREQ_RST, default 12'h001, meaning the reset value of cr_baud_freq.
REQ-004 SHALL have parameter BAUD_LIMIT_RST, default 16'h0001, meaning the reset value of cr_baud_limit.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; one clock domain, and all logic is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have Avalon-MM slave ports: avmms_write_i, avmms_read_i (in, 1); avmms_address_i (in, 3); avmms_writedata_i (in, 32); avmms_byteenable_i (in, 4); avmms_waitrequest_o (out, 1); avmms_readdata_o (out, 32).
REQ-008 SHALL have config outputs: cr_pbit (1), cr_ptype (1), cr_sbit (2), cr_dbits (4), cr_baud_freq (12), cr_baud_limit (16).
REQ-009 SHALL have TX-side ports: fifo_tx_empty, fifo_tx_full (in, 1); fifo_tx_fill (in, FILL_W); tx_data (out, DATA_BITS); tx_valid (out, 1).
REQ-010 SHALL have RX-side ports: fifo_rx_empty, fifo_rx_full (in, 1); fifo_rx_fill (in, FILL_W); rx_overrun_i (in, 1, one-cycle pulse); rx_read (out, 1); rx_readdata (in, DATA_BITS+1, MSB = parity error); rx_readdatavalid (in, 1).
REQ-011 SHALL have port irq_o, output, 1 bit: the registered level interrupt.

Function
REQ-012 SHALL implement a bus FSM with states IDLE, ACK, RX_WAIT; avmms_waitrequest_o SHALL be low only in ACK, which lasts exactly one cycle, then the FSM returns to IDLE.
REQ-013 IDLE with write, or read of any address other than 5: SHALL go to ACK next cycle; the write is committed, or readdata is valid, in the ACK cycle.
REQ-014 IDLE with read of address 5 and fifo_rx_empty=0: SHALL pulse rx_read for exactly one cycle and enter RX_WAIT; RX_WAIT SHALL hold until rx_readdatavalid, capture the data, and go to ACK.
REQ-015 Read of address 5 with fifo_rx_empty=1: SHALL issue no rx_read and go to ACK with readdata bit31=0, all other bits 0.
REQ-016 Register map, address 0 (CONTROL): bits [3:0] = {tx_full, tx_empty, rx_full, rx_empty} (RO); [8] pbit; [9] ptype; [11:10] sbit; [15:12] dbits (RW); all other bits read as 0.
REQ-017 A dbits write outside 5..DATA_BITS SHALL be clamped to DATA_BITS.
REQ-018 Address 1 (BAUD, RW): SHALL be {4'h0, freq[11:0], limit[15:0]}.
REQ-019 Address 2 (TX_FILL) and address 3 (RX_FILL) SHALL be RO and zero-extended to 32 bits.
REQ-020 Address 4 (TX_DATA, WO): SHALL drive tx_data = writedata[DATA_BITS-1:0] with a one-cycle tx_valid when fifo_tx_full=0; when fifo_tx_full=1 it SHALL drop the data and set IRQ_STAT[3].
REQ-021 Address 5 (RX_DATA, RO): SHALL read {valid bit31, zeros, parity_err, data}.
REQ-022 Address 6 (IRQ_EN, RW): bits [3:0].
REQ-023 Address 7 (IRQ_STAT, W1C): bits [3:0].
REQ-024 Writes to RW registers SHALL honour byteenable per byte lane; a lane with byteenable=0 leaves that lane unchanged.
REQ-025 A write to a RO address SHALL be acknowledged and otherwise ignored.
REQ-026 IRQ_STAT bits: [0] rx_not_empty = live !fifo_rx_empty, not sticky; [1] tx_empty = live fifo_tx_empty, not sticky; [2] rx_overrun = sticky set by rx_overrun_i; [3] tx_overflow = sticky.
REQ-027 When set and W1C occur in the same cycle, set SHALL win.
REQ-028 irq_o SHALL be the registered value of |(IRQ_STAT & IRQ_EN), i.e. one cycle after the cause.
REQ-029 While the FSM is not IDLE, new avmms_read_i/avmms_write_i SHALL be held off by waitrequest and not sampled.

Reset
REQ-030 SHALL reset asynchronously on reset_n low: FSM=IDLE, waitrequest=1, readdata=0, tx_valid=0, rx_read=0, irq_o=0, IRQ_EN=0, sticky bits=0, pbit=0, ptype=0, sbit=0, dbits=DATA_BITS, baud registers=parameter defaults.
REQ-031 Reset asserted during RX_WAIT SHALL abort the transfer; a later rx_readdatavalid while in IDLE SHALL be ignored.

Structure
REQ-032 Register addresses, the IRQ bit indices and the FSM state enum SHALL live in package uart_pkg.
REQ-033 The IRQ status/enable/output logic SHALL be sub-module uart_irq_ctrl.

Verification
REQ-034 Write 0x0000_0B00 to addr 0 with byteenable=4'b0010 -> pbit=1, ptype=1, sbit=2'b10; waitrequest low exactly one cycle.
REQ-035 Write 0x0064_0208 to addr 1 with byteenable=4'b0011 -> limit=0x0208, freq unchanged from reset.
REQ-036 Write 0x1A5 to addr 4 with tx_full=0 -> tx_valid for 1 cycle, tx_data=0xA5 (DATA_BITS=8); same write with tx_full=1 -> no tx_valid, IRQ_STAT[3]=1.
REQ-037 Read addr 5, rx_readdatavalid 3 cycles after rx_read with 0x1_3C -> single rx_read pulse, readdata=0x8000_013C; read with rx_empty=1 -> readdata 0, no rx_read.
REQ-038 IRQ_EN=4'b0100, pulse rx_overrun_i -> irq_o=1 next cycle; W1C 0x4 coincident with a new overrun pulse -> bit stays 1.
REQ-039 Assert reset_n low during RX_WAIT, then drive rx_readdatavalid -> all outputs at reset values, FSM stays IDLE.
